// File: rtl/apb_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl_if
// Bundles the command/response port and the APB3 bus of apb_master_ctrl.
//   master modport : the bridge side (takes commands, drives the APB bus)
//   slave modport  : the environment side (issues commands, models slaves)
// Signals
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command handshake
//   rsp_valid/rsp_rdata/rsp_err                      : one-cycle response
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA                 : APB request
//   PRDATA/PREADY/PSLVERR                            : APB completion
// ---------------------------------------------------------------------------
interface apb_master_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
// APB3 bridge master. Accepts single read/write commands on a valid/ready
// port, runs SETUP/ACCESS to one of NUM_SLAVES slaves decoded from the top
// address bits, and returns a one-cycle response pulse. Back-to-back
// commands are taken on the completing ACCESS cycle (no IDLE bubble).
//
// Ports
//   PCLK    : clock, rising edge
//   PRESET  : asynchronous active-high reset; aborts any transfer silently
//   bus     : apb_master_ctrl_if.master (command, response and APB signals)
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   : an ACCESS phase stretched to TIMEOUT cycles by PREADY=0 is
//               ended with rsp_err=1
//   undefined : ACCESS waits for PREADY indefinitely, TIMEOUT unused
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer, cmd_ready=1
// SETUP  | APB setup phase, PSEL asserted, PENABLE=0
// ACCESS | APB access phase, PENABLE=1, waits for PREADY
// DERR   | decode-error response pending after a back-to-back accept
// ---------------------------------------------------------------------------
module apb_master_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_ctrl_if.master    bus
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  take;
    logic [SEL_W-1:0]      cmd_idx;
    logic                  cmd_hit;
    logic [NUM_SLAVES-1:0] cmd_onehot;

    // ---------------------------------------------------------------------
    // Slave decode from the top address bits
    // ---------------------------------------------------------------------
    assign cmd_idx = bus.cmd_addr[ADDR_W-1 -: SEL_W];

    // When NUM_SLAVES is a power of two every index is a valid slave.
    if (NUM_SLAVES == (1 << SEL_W)) begin : g_full_decode
        assign cmd_hit = 1'b1;
    end else begin : g_part_decode
        assign cmd_hit = (int'(cmd_idx) < NUM_SLAVES);
    end

    assign cmd_onehot = cmd_hit ? (NUM_SLAVES'(1) << cmd_idx) : '0;

    // ---------------------------------------------------------------------
    // Access timeout (down-counter, terminal count at zero)
    // ---------------------------------------------------------------------
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] timer_q, timer_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        take        = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        timer_d     = timer_q;
`endif

        case (state_q)
            IDLE: begin
                take = 1'b1;
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                if (bus.PREADY) begin
                    take        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timer_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                end else begin
                    timer_d = timer_q - TO_W'(1);
                end
`endif
            end

            DERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // New command, either from IDLE or on the completing ACCESS cycle.
        if (take && bus.cmd_valid) begin
            if (cmd_hit) begin
                state_d   = SETUP;
                psel_d    = cmd_onehot;
                penable_d = 1'b0;
                pwrite_d  = bus.cmd_write;
                paddr_d   = bus.cmd_addr;
                pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
`ifdef APB_MASTER_TIMEOUT_EN
                timer_d   = TO_LOAD;
`endif
            end else if (state_q == IDLE) begin
                // Decode error answered on the next cycle, no APB phase.
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                state_d     = IDLE;
                psel_d      = '0;
                penable_d   = 1'b0;
            end else begin
                // Response slot of the finishing transfer is taken; the
                // decode error is answered one cycle later from DERR.
                state_d   = DERR;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign bus.cmd_ready = take;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_master_ctrl
// Directed bench for apb_master_ctrl: one 4-slave instance (TIMEOUT=8) and
// one 3-slave instance for the out-of-range decode case. Slave index is the
// top SEL_W address bits, so with 4 slaves 0x1..=slave0, 0x4..=slave1,
// 0x8..=slave2, 0xC..=slave3.
// ---------------------------------------------------------------------------
module tb_apb_master_ctrl;

    logic PCLK;
    logic PRESET;

    int n_tests = 0;
    int n_fail  = 0;

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus4 ();
    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) bus3 ();

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(8)) u_dut4 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus4.master)
    );

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(8)) u_dut3 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus3.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic samp();
        @(negedge PCLK);
    endtask

    task automatic drive4(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        bus4.cmd_valid = 1'b1;
        bus4.cmd_write = wr;
        bus4.cmd_addr  = addr;
        bus4.cmd_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rsp_seen;

        PRESET         = 1'b1;
        bus4.cmd_valid = 1'b0;
        bus4.cmd_write = 1'b0;
        bus4.cmd_addr  = '0;
        bus4.cmd_wdata = '0;
        bus4.PRDATA    = '0;
        bus4.PREADY    = 1'b1;
        bus4.PSLVERR   = 1'b0;
        bus3.cmd_valid = 1'b0;
        bus3.cmd_write = 1'b0;
        bus3.cmd_addr  = '0;
        bus3.cmd_wdata = '0;
        bus3.PRDATA    = '0;
        bus3.PREADY    = 1'b1;
        bus3.PSLVERR   = 1'b0;

        // Reset state
        repeat (2) step();
        samp();
        chk("rst_psel",    bus4.PSEL,      4'b0000);
        chk("rst_penable", bus4.PENABLE,   1'b0);
        chk("rst_pwrite",  bus4.PWRITE,    1'b0);
        chk("rst_paddr",   bus4.PADDR,     32'h0);
        chk("rst_pwdata",  bus4.PWDATA,    32'h0);
        chk("rst_rsp_v",   bus4.rsp_valid, 1'b0);
        chk("rst_rsp_d",   bus4.rsp_rdata, 32'h0);
        chk("rst_rsp_e",   bus4.rsp_err,   1'b0);
        step();
        PRESET = 1'b0;
        step();

        // Single write, zero wait states
        drive4(1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        samp();
        chk("t1_ready", bus4.cmd_ready, 1'b1);
        step();
        bus4.cmd_valid = 1'b0;
        samp();
        chk("t1_setup_psel",   bus4.PSEL,    4'b0001);
        chk("t1_setup_pen",    bus4.PENABLE, 1'b0);
        chk("t1_setup_pwrite", bus4.PWRITE,  1'b1);
        chk("t1_setup_paddr",  bus4.PADDR,   32'h1000_0004);
        chk("t1_setup_pwdata", bus4.PWDATA,  32'hDEAD_BEEF);
        chk("t1_setup_rdy",    bus4.cmd_ready, 1'b0);
        step();
        samp();
        chk("t1_acc_psel",   bus4.PSEL,    4'b0001);
        chk("t1_acc_pen",    bus4.PENABLE, 1'b1);
        chk("t1_acc_pwdata", bus4.PWDATA,  32'hDEAD_BEEF);
        chk("t1_acc_rsp_v",  bus4.rsp_valid, 1'b0);
        step();
        samp();
        chk("t1_rsp_v",    bus4.rsp_valid, 1'b1);
        chk("t1_rsp_e",    bus4.rsp_err,   1'b0);
        chk("t1_rsp_d",    bus4.rsp_rdata, 32'h0);
        chk("t1_end_psel", bus4.PSEL,      4'b0000);
        chk("t1_end_pen",  bus4.PENABLE,   1'b0);
        step();
        samp();
        chk("t1_rsp_pulse", bus4.rsp_valid, 1'b0);

        // Read with three wait states; PRDATA garbage while waiting
        bus4.PREADY = 1'b0;
        bus4.PRDATA = 32'hBAD0_BAD0;
        drive4(1'b0, 32'h4000_0010, 32'hFFFF_FFFF);
        step();
        bus4.cmd_valid = 1'b0;
        samp();
        chk("t2_setup_psel",   bus4.PSEL,   4'b0010);
        chk("t2_setup_pwrite", bus4.PWRITE, 1'b0);
        chk("t2_setup_pwdata", bus4.PWDATA, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            samp();
            chk("t2_wait_pen",   bus4.PENABLE,   1'b1);
            chk("t2_wait_psel",  bus4.PSEL,      4'b0010);
            chk("t2_wait_paddr", bus4.PADDR,     32'h4000_0010);
            chk("t2_wait_rdy",   bus4.cmd_ready, 1'b0);
            chk("t2_wait_rsp",   bus4.rsp_valid, 1'b0);
        end
        step();
        bus4.PREADY = 1'b1;
        bus4.PRDATA = 32'h1234_5678;
        samp();
        chk("t2_last_pen",  bus4.PENABLE,   1'b1);
        chk("t2_last_psel", bus4.PSEL,      4'b0010);
        chk("t2_last_rdy",  bus4.cmd_ready, 1'b1);
        step();
        bus4.PRDATA = 32'h0;
        samp();
        chk("t2_rsp_v",    bus4.rsp_valid, 1'b1);
        chk("t2_rsp_d",    bus4.rsp_rdata, 32'h1234_5678);
        chk("t2_rsp_e",    bus4.rsp_err,   1'b0);
        chk("t2_end_psel", bus4.PSEL,      4'b0000);

        // Back-to-back write then read, cmd_valid held
        bus4.PRDATA = 32'hCAFE_F00D;
        drive4(1'b1, 32'h0000_0020, 32'h1111_1111);
        step();
        drive4(1'b0, 32'h8000_0030, 32'h2222_2222);
        samp();
        chk("t3_w_setup_psel", bus4.PSEL,      4'b0001);
        chk("t3_w_setup_pen",  bus4.PENABLE,   1'b0);
        chk("t3_w_setup_rdy",  bus4.cmd_ready, 1'b0);
        step();
        samp();
        chk("t3_w_acc_pen", bus4.PENABLE,   1'b1);
        chk("t3_w_acc_rdy", bus4.cmd_ready, 1'b1);
        step();
        bus4.cmd_valid = 1'b0;
        samp();
        chk("t3_w_rsp_v",      bus4.rsp_valid, 1'b1);
        chk("t3_w_rsp_d",      bus4.rsp_rdata, 32'h0);
        chk("t3_r_setup_pen",  bus4.PENABLE,   1'b0);
        chk("t3_r_setup_psel", bus4.PSEL,      4'b0100);
        chk("t3_r_setup_pwr",  bus4.PWRITE,    1'b0);
        chk("t3_r_setup_addr", bus4.PADDR,     32'h8000_0030);
        step();
        samp();
        chk("t3_r_acc_pen", bus4.PENABLE,   1'b1);
        chk("t3_gap_rsp",   bus4.rsp_valid, 1'b0);
        step();
        samp();
        chk("t3_r_rsp_v",  bus4.rsp_valid, 1'b1);
        chk("t3_r_rsp_d",  bus4.rsp_rdata, 32'hCAFE_F00D);
        chk("t3_end_psel", bus4.PSEL,      4'b0000);

        // PSLVERR on a write
        bus4.PSLVERR = 1'b1;
        drive4(1'b1, 32'h2000_0000, 32'h0000_0055);
        step();
        bus4.cmd_valid = 1'b0;
        step();
        step();
        samp();
        chk("t4_rsp_v", bus4.rsp_valid, 1'b1);
        chk("t4_rsp_e", bus4.rsp_err,   1'b1);
        step();
        bus4.PSLVERR = 1'b0;

        // Decode error on the 3-slave instance
        bus3.cmd_valid = 1'b1;
        bus3.cmd_write = 1'b1;
        bus3.cmd_addr  = 32'hC000_0000;
        bus3.cmd_wdata = 32'h0000_0099;
        samp();
        chk("t5_ready", bus3.cmd_ready, 1'b1);
        step();
        bus3.cmd_valid = 1'b0;
        samp();
        chk("t5_rsp_v", bus3.rsp_valid, 1'b1);
        chk("t5_rsp_e", bus3.rsp_err,   1'b1);
        chk("t5_rsp_d", bus3.rsp_rdata, 32'h0);
        chk("t5_psel",  bus3.PSEL,      3'b000);
        chk("t5_pen",   bus3.PENABLE,   1'b0);
        step();
        samp();
        chk("t5_rsp_pulse", bus3.rsp_valid, 1'b0);
        chk("t5_idle_rdy",  bus3.cmd_ready, 1'b1);

        // Highest valid slave on the 3-slave instance
        bus3.PRDATA    = 32'h0000_0077;
        bus3.cmd_valid = 1'b1;
        bus3.cmd_write = 1'b0;
        bus3.cmd_addr  = 32'h8000_0000;
        step();
        bus3.cmd_valid = 1'b0;
        samp();
        chk("t5b_psel", bus3.PSEL, 3'b100);
        step();
        step();
        samp();
        chk("t5b_rsp_v", bus3.rsp_valid, 1'b1);
        chk("t5b_rsp_e", bus3.rsp_err,   1'b0);
        chk("t5b_rsp_d", bus3.rsp_rdata, 32'h0000_0077);

        // Reset during an ACCESS wait state
        bus4.PREADY = 1'b0;
        drive4(1'b0, 32'h4000_0000, 32'h0);
        step();
        bus4.cmd_valid = 1'b0;
        step();
        samp();
        chk("t6_pre_pen", bus4.PENABLE, 1'b1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("t6_rst_psel",  bus4.PSEL,      4'b0000);
        chk("t6_rst_pen",   bus4.PENABLE,   1'b0);
        chk("t6_rst_paddr", bus4.PADDR,     32'h0);
        chk("t6_rst_rsp",   bus4.rsp_valid, 1'b0);
        step();
        PRESET      = 1'b0;
        bus4.PREADY = 1'b1;
        rsp_seen    = 0;
        for (int i = 0; i < 3; i++) begin
            samp();
            if (bus4.rsp_valid) rsp_seen++;
            step();
        end
        chk("t6_no_rsp", rsp_seen, 0);
        drive4(1'b1, 32'h1000_0008, 32'h0000_A5A5);
        step();
        bus4.cmd_valid = 1'b0;
        samp();
        chk("t6_after_psel", bus4.PSEL, 4'b0001);
        step();
        step();
        samp();
        chk("t6_after_rsp_v", bus4.rsp_valid, 1'b1);
        chk("t6_after_rsp_e", bus4.rsp_err,   1'b0);
        step();

        // PREADY held low
        bus4.PREADY = 1'b0;
        drive4(1'b1, 32'h0000_0040, 32'h0000_0001);
        step();
        bus4.cmd_valid = 1'b0;
        samp();
        chk("t7_setup_pen", bus4.PENABLE, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            step();
            samp();
            chk("t7_wait_pen", bus4.PENABLE,   1'b1);
            chk("t7_wait_rsp", bus4.rsp_valid, 1'b0);
        end
        step();
        samp();
        chk("t7_to_rsp_v", bus4.rsp_valid, 1'b1);
        chk("t7_to_rsp_e", bus4.rsp_err,   1'b1);
        chk("t7_to_rsp_d", bus4.rsp_rdata, 32'h0);
        chk("t7_to_psel",  bus4.PSEL,      4'b0000);
        chk("t7_to_pen",   bus4.PENABLE,   1'b0);
        bus4.PREADY = 1'b1;
`else
        for (int i = 0; i < 20; i++) begin
            step();
            samp();
            chk("t7_wait_pen", bus4.PENABLE,   1'b1);
            chk("t7_wait_rsp", bus4.rsp_valid, 1'b0);
        end
        step();
        bus4.PREADY = 1'b1;
        samp();
        chk("t7_late_rdy", bus4.cmd_ready, 1'b1);
        step();
        samp();
        chk("t7_late_rsp_v", bus4.rsp_valid, 1'b1);
        chk("t7_late_rsp_e", bus4.rsp_err,   1'b0);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
